alu_pipe_stage: RTL

Two-stage registered ALU stage that sits directly upstream of the result consumer and wraps the 32-bit bitwise/arithmetic units (and_32 and siblings).
- Captures operands A/B and an opcode through a valid/ready handshake.
- Drives the combinational units from registered operands.
- Registers result R plus flags for the downstream stage.
- Throughput: one operation per cycle; full backpressure support.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/add_32.sv | 11 +
 rtl/alu_core.sv | 57 +++++
 rtl/and_32.sv | 8 +
 rtl/nor_32.sv | 8 +
 rtl/or_32.sv | 8 +
 rtl/sll_32.sv | 8 +
 rtl/xor_32.sv | 8 +
 rtl/alu_pipe_stage.sv | 99 +++++++++
 9 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operand width, opcode encoding and the result/flags bundle
// shared by alu_core and alu_pipe_stage.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SUB = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             carry;
    logic             ovf;
  } alu_res_t;

endpackage

// File: rtl/add_32.sv
// add_32: 32-bit adder with carry-in and carry-out; subtraction is done by
// the caller feeding ~b with cin = 1.
module add_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU built from the 32-bit units, muxed by
// opcode, producing the result plus zero/carry/overflow flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output alu_res_t         res
);

  alu_op_e          op_e;
  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] nor_y;
  logic [WIDTH-1:0] sll_y;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             use_sub;
  logic             cout;
  logic             ovf_raw;

  assign op_e = alu_op_e'(op);

  // SLT shares the subtract path: signed A<B is the difference sign corrected by overflow
  assign use_sub = (op_e == OP_SUB) || (op_e == OP_SLT);
  assign add_b   = use_sub ? ~b : b;
  assign ovf_raw = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  and_32 u_and (.a(a), .b(b), .y(and_y));
  or_32  u_or  (.a(a), .b(b), .y(or_y));
  xor_32 u_xor (.a(a), .b(b), .y(xor_y));
  nor_32 u_nor (.a(a), .b(b), .y(nor_y));
  add_32 u_add (.a(a), .b(add_b), .cin(use_sub), .sum(sum), .cout(cout));
  sll_32 u_sll (.a(a), .shamt(b[4:0]), .y(sll_y));

  always_comb begin
    res = '0;
    case (op_e)
      OP_AND: res.r = and_y;
      OP_OR:  res.r = or_y;
      OP_XOR: res.r = xor_y;
      OP_NOR: res.r = nor_y;
      OP_SLL: res.r = sll_y;
      OP_SLT: res.r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      OP_ADD, OP_SUB: begin
        res.r     = sum;
        res.carry = cout;
        res.ovf   = ovf_raw;
      end
      default: res.r = '0;
    endcase
    res.zero = (res.r == '0);
  end

endmodule

// File: rtl/and_32.sv
// and_32: 32-bit bitwise AND unit.
module and_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a & b;
endmodule

// File: rtl/nor_32.sv
// nor_32: 32-bit bitwise NOR unit.
module nor_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/or_32.sv
// or_32: 32-bit bitwise OR unit.
module or_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a | b;
endmodule

// File: rtl/sll_32.sv
// sll_32: 32-bit logical left shift by a 5-bit amount.
module sll_32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a << shamt;
endmodule

// File: rtl/xor_32.sv
// xor_32: 32-bit bitwise XOR unit.
module xor_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: two-register valid/ready ALU stage (operands, then result).
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`endif
);

  import alu_pkg::*;

  logic             v1;
  logic             v2;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             load1;
  logic             load2;
  alu_res_t         core_res;

  // Stage 1 can refill on the same edge it hands off, so readiness looks through to stage 2
  assign in_ready  = !v1 || !v2 || out_ready;
  assign load1     = in_valid && in_ready;
  assign load2     = v1 && (!v2 || out_ready);
  assign out_valid = v2;

  alu_core u_core (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (core_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load1) begin
      v1   <= 1'b1;
      op_q <= in_op;
      a_q  <= in_a;
      b_q  <= in_b;
    end else if (load2) begin
      v1   <= 1'b0;
    end
  end

  // Result is held untouched while the consumer stalls; only v2 drops after a consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      out_r     <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (load2) begin
      v2        <= 1'b1;
      out_r     <= core_res.r;
      out_zero  <= core_res.zero;
      out_carry <= core_res.carry;
      out_ovf   <= core_res.ovf;
    end else if (out_ready) begin
      v2        <= 1'b0;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // A new overflow takes priority over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (load2 && core_res.ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule
